// File: rtl/mini_core_accel_pkg.sv
// Shared types and CR address map for the mini-core accelerator farm.
// Lane state enum, per-lane operand/result bundles and region bounds.
package mini_core_accel_pkg;

    localparam int INT8_MULTIPLIER_NUM = 16;

    localparam logic [31:0] CR_MEM_REGION_FLOOR = 32'h00FE_0000;
    localparam logic [31:0] CR_MEM_REGION_ROOF  = 32'h00FE_FFFF;
    localparam logic [31:0] CR_MULTIPLICANT_0   = 32'h00FE_F000;
    localparam logic [31:0] CR_MULTIPLIER_0     = 32'h00FE_F001;
    localparam logic [31:0] CR_MUL2CORE_INT8_0  = 32'h00FE_F050;
    localparam logic [31:0] CR_DONE_0           = 32'h00FE_F051;
    localparam logic [31:0] CR_DEBUG_0          = 32'h00FE_FF00;

    typedef struct packed {
        logic [7:0] multiplicant;
        logic [7:0] multiplier;
    } t_mul_input;

    typedef struct packed {
        logic [15:0] result;
        logic        done;
    } t_mul_output;

    typedef t_mul_input  [INT8_MULTIPLIER_NUM-1:0] t_accel_farm_input;
    typedef t_mul_output [INT8_MULTIPLIER_NUM-1:0] t_accel_farm_output;
    typedef logic [31:0] t_cr_debug;

    typedef enum logic [1:0] {IDLE, BUSY, READY} t_cr_lane_state;

    // Lane CRs are interleaved two bytes apart from each block base.
    function automatic logic [31:0] lane_addr(logic [31:0] base, int lane);
        return base + 32'(2 * lane);
    endfunction

endpackage

// File: rtl/mini_core_accel_cr_if.sv
// Core-side CR access bundle for the accelerator control registers.
// The core data-memory stage is master; the CR block is slave.
interface mini_core_accel_cr_if #(
    parameter int ADDR_W = 32
);
    logic              cr_rd_en;
    logic              cr_wr_en;
    logic [ADDR_W-1:0] cr_addr;
    logic [31:0]       cr_wr_data;
    logic [31:0]       cr_rd_data;
    logic              cr_hit;

    modport master (
        output cr_rd_en, cr_wr_en, cr_addr, cr_wr_data,
        input  cr_rd_data, cr_hit
    );

    modport slave (
        input  cr_rd_en, cr_wr_en, cr_addr, cr_wr_data,
        output cr_rd_data, cr_hit
    );
endinterface

// File: rtl/mini_core_accel_cr_lane.sv
// One multiplier lane: operand registers, start pulse and result capture.
// done is high exactly while the lane sits in READY.
module mini_core_accel_cr_lane
    import mini_core_accel_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_multiplicant,
    input  logic        wr_multiplier,
    input  logic [7:0]  wr_data,
    input  t_mul_output mul_out,
    output logic [7:0]  multiplicant,
    output logic [7:0]  multiplier,
    output logic        start,
    output logic [15:0] result,
    output logic        done
);
    t_cr_lane_state state, state_n;
    logic start_n;
    logic capture;

    // State, start pulse, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            start        <= 1'b0;
            multiplicant <= '0;
            multiplier   <= '0;
            result       <= '0;
        end else begin
            state <= state_n;
            start <= start_n;
            if (wr_multiplicant) multiplicant <= wr_data;
            if (wr_multiplier)   multiplier   <= wr_data;
            if (capture)         result       <= mul_out.result;
        end
    end

    // Next state: core writes beat a same-cycle done; done is ignored
    // while a start pulse is on the wire.
    always_comb begin
        state_n = state;
        start_n = 1'b0;
        capture = 1'b0;
        if (wr_multiplier) begin
            state_n = BUSY;
            start_n = 1'b1;
        end else if (wr_multiplicant) begin
            if (state == BUSY) start_n = 1'b1;
            else               state_n = IDLE;
        end else if (state == BUSY && mul_out.done && !start) begin
            capture = 1'b1;
            state_n = READY;
        end
    end

    assign done = (state == READY);

endmodule

// File: rtl/mini_core_accel_cr.sv
// CR slave for the int8 multiplier farm: decode, read mux, lane array.
// MINI_CORE_ACCEL_CR_DEBUG_EN builds the CR_DEBUG_0 scratch register.
module mini_core_accel_cr
    import mini_core_accel_pkg::*;
#(
    parameter int LANES  = INT8_MULTIPLIER_NUM,
    parameter int ADDR_W = 32
) (
    input  logic                   Clk,
    input  logic                   RstN,
    mini_core_accel_cr_if.slave    cr,
    output t_accel_farm_input      accel_farm_input,
    output logic [LANES-1:0]       core2mul_start,
    input  t_accel_farm_output     accel_farm_output
);
    logic [7:0]  mcand  [LANES];
    logic [7:0]  mplier [LANES];
    logic [15:0] result [LANES];
    logic [LANES-1:0] lane_done;
    logic [31:0] rd_next;
    logic [31:0] rd_q;

    assign cr.cr_hit = (cr.cr_addr >= ADDR_W'(CR_MEM_REGION_FLOOR)) &&
                       (cr.cr_addr <= ADDR_W'(CR_MEM_REGION_ROOF));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic wr_mc;
        logic wr_mp;
        assign wr_mc = cr.cr_wr_en &&
            (cr.cr_addr == ADDR_W'(lane_addr(CR_MULTIPLICANT_0, i)));
        assign wr_mp = cr.cr_wr_en &&
            (cr.cr_addr == ADDR_W'(lane_addr(CR_MULTIPLIER_0, i)));

        mini_core_accel_cr_lane u_lane (
            .clk             (Clk),
            .rst_n           (RstN),
            .wr_multiplicant (wr_mc),
            .wr_multiplier   (wr_mp),
            .wr_data         (cr.cr_wr_data[7:0]),
            .mul_out         (accel_farm_output[i]),
            .multiplicant    (mcand[i]),
            .multiplier      (mplier[i]),
            .start           (core2mul_start[i]),
            .result          (result[i]),
            .done            (lane_done[i])
        );
    end

    // Operand bundle toward the farm; unused lanes stay at zero.
    always_comb begin
        accel_farm_input = '0;
        for (int i = 0; i < LANES; i++) begin
            accel_farm_input[i].multiplicant = mcand[i];
            accel_farm_input[i].multiplier   = mplier[i];
        end
    end

`ifdef MINI_CORE_ACCEL_CR_DEBUG_EN
    t_cr_debug debug_q;

    // Debug scratch register, full 32-bit write.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            debug_q <= '0;
        end else if (cr.cr_wr_en &&
                     cr.cr_addr == ADDR_W'(CR_DEBUG_0)) begin
            debug_q <= cr.cr_wr_data;
        end
    end
`else
    logic unused_wr_data;
    assign unused_wr_data = ^cr.cr_wr_data[31:8];
`endif

    // Read mux over pre-write register values; misses return zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cr.cr_addr == ADDR_W'(lane_addr(CR_MULTIPLICANT_0, i)))
                rd_next = {24'b0, mcand[i]};
            if (cr.cr_addr == ADDR_W'(lane_addr(CR_MULTIPLIER_0, i)))
                rd_next = {24'b0, mplier[i]};
            if (cr.cr_addr == ADDR_W'(lane_addr(CR_MUL2CORE_INT8_0, i)))
                rd_next = {16'b0, result[i]};
            if (cr.cr_addr == ADDR_W'(lane_addr(CR_DONE_0, i)))
                rd_next = {31'b0, lane_done[i]};
        end
`ifdef MINI_CORE_ACCEL_CR_DEBUG_EN
        if (cr.cr_addr == ADDR_W'(CR_DEBUG_0))
            rd_next = debug_q;
`endif
    end

    // Registered read data, one-cycle latency.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN)            rd_q <= '0;
        else if (cr.cr_rd_en) rd_q <= rd_next;
    end

    assign cr.cr_rd_data = rd_q;

endmodule
